// File: rtl/operand_sequencer.sv
// operand_sequencer: latches one A row and one B column on start, then steps a
// shared element index through them under a valid/ready handshake toward the
// downstream MAC, and pulses done once the last pair has been accepted.
module operand_sequencer #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_INPUTS*WIDTH-1:0] row_in,
  input  logic [NUM_INPUTS*WIDTH-1:0] col_in,
  output logic [NUM_INPUTS*WIDTH-1:0] row_bus,
  output logic [NUM_INPUTS*WIDTH-1:0] col_bus,
  output logic [NUM_INPUTS-1:0]       sel,
  output logic                        valid,
  input  logic                        ready,
  output logic                        last,
  output logic                        busy,
  output logic                        done
);

  localparam int BUS_W = NUM_INPUTS * WIDTH;
  // Index of the final element; fits in NUM_INPUTS bits for any NUM_INPUTS >= 1.
  localparam logic [NUM_INPUTS-1:0] LAST_IDX = NUM_INPUTS'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [BUS_W-1:0]        row_reg, row_next;
  logic [BUS_W-1:0]        col_reg, col_next;
  logic [NUM_INPUTS-1:0]   sel_reg, sel_next;
  logic                    valid_reg, valid_next;
  logic                    last_reg, last_next;
  logic                    done_reg, done_next;
  logic [NUM_INPUTS-1:0]   sel_inc;

  assign sel_inc = sel_reg + NUM_INPUTS'(1);

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      sel_reg   <= sel_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: everything holds unless a start, a transfer or the DONE exit changes it.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    sel_next   = sel_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          row_next   = row_in;
          col_next   = col_in;
          sel_next   = '0;
          valid_next = 1'b1;
          last_next  = (NUM_INPUTS == 1);
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (valid_reg && ready) begin
          if (last_reg) begin
            sel_next   = '0;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            sel_next  = sel_inc;
            last_next = (sel_inc == LAST_IDX);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign row_bus = row_reg;
  assign col_bus = col_reg;
  assign sel     = sel_reg;
  assign valid   = valid_reg;
  assign last    = last_reg;
  assign done    = done_reg;
  assign busy    = (state_reg != IDLE);

endmodule
